// File: rtl/framebuffer_scanout_if.sv
// Raster, framebuffer-read and palette-write signals of the scan-out stage.
// The scan-out side uses the master modport; the sync generator, RAM and CPU side use slave.
interface framebuffer_scanout_if #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned BPP    = 1
);
  logic              video_on;
  logic [9:0]        pixel_x;
  logic [9:0]        pixel_y;
  logic [ADDR_W-1:0] address_out;
  logic [BPP-1:0]    data_in;
  logic              mode;
  logic              pal_we;
  logic [BPP-1:0]    pal_idx;
  logic [2:0]        pal_data;
  logic [2:0]        rgb;

  modport master (
    input  video_on, pixel_x, pixel_y, data_in, mode, pal_we, pal_idx, pal_data,
    output address_out, rgb
  );

  modport slave (
    output video_on, pixel_x, pixel_y, data_in, mode, pal_we, pal_idx, pal_data,
    input  address_out, rgb
  );
endinterface

// File: rtl/framebuffer_scanout.sv
// Framebuffer scan-out: raster position -> downscaled read address, then the
// returned pixel -> 3-bit RGB by MSB replication or palette lookup.
module framebuffer_scanout #(
  parameter int unsigned H_RES       = 640,
  parameter int unsigned V_RES       = 480,
  parameter int unsigned SCALE_SHIFT = 1,
  parameter int unsigned BPP         = 1,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned ADDR_W      = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  framebuffer_scanout_if.master bus
);

  localparam int unsigned FB_W  = H_RES >> SCALE_SHIFT;
  localparam int unsigned SUB_W = (SCALE_SHIFT == 0) ? 1 : SCALE_SHIFT;
  localparam int unsigned PAL_N = 1 << BPP;
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'((1 << SCALE_SHIFT) - 1);

  logic [ADDR_W-1:0]      line_base;
  logic [SUB_W-1:0]       row_sub;
  logic [ADDR_W-1:0]      address_q;
  logic [MEM_LATENCY-1:0] vld_q;
  logic [2:0]             rgb_q;
  logic [2:0]             rgb_c;
  logic [2:0]             palette [PAL_N];

  logic       line_end_c;
  logic       frame_end_c;
  logic       in_range_c;
  logic [9:0] col_c;

  assign line_end_c  = (bus.pixel_x == 10'(H_RES));
  assign frame_end_c = (bus.pixel_y >= 10'(V_RES - 1));
  assign in_range_c  = bus.video_on && (bus.pixel_x < 10'(H_RES)) && (bus.pixel_y < 10'(V_RES));
  assign col_c       = bus.pixel_x >> SCALE_SHIFT;

  // Line-base accumulator: advances by one framebuffer row every 2^SCALE_SHIFT raster lines.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_base <= '0;
      row_sub   <= '0;
    end else if (line_end_c) begin
      if (frame_end_c) begin
        line_base <= '0;
        row_sub   <= '0;
      end else if (row_sub == SUB_MAX) begin
        row_sub   <= '0;
        line_base <= line_base + ADDR_W'(FB_W);
      end else begin
        row_sub <= row_sub + SUB_W'(1);
      end
    end
  end

  // Address stage; holds the last active address through blanking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      address_q <= '0;
    end else if (in_range_c) begin
      address_q <= line_base + ADDR_W'(col_c);
    end
  end

  // Valid delay line; its last stage lines up with data_in at the colour edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
    end else begin
      vld_q <= MEM_LATENCY'({vld_q, in_range_c});
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PAL_N; i++) begin
        palette[i] <= (i == 0) ? 3'b000 : 3'b111;
      end
    end else if (bus.pal_we) begin
      palette[bus.pal_idx] <= bus.pal_data;
    end
  end

  // Colour select; mode is taken live here rather than pipelined with the pixel.
  always_comb begin
    rgb_c = 3'b000;
    if (vld_q[MEM_LATENCY-1]) begin
      if (bus.mode) begin
        rgb_c = palette[bus.data_in];
      end else begin
        rgb_c = {3{bus.data_in[BPP-1]}};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q <= 3'b000;
    end else begin
      rgb_q <= rgb_c;
    end
  end

  assign bus.address_out = address_q;
  assign bus.rgb         = rgb_q;

endmodule
